lsu_stage: RTL and testbench

LSU_STAGE -- requirements
Module: lsu_stage

---
 rtl/lsu_stage.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// Single-outstanding load/store stage: IDLE -> ISSUE -> (CAPTURE) -> RESP.
// Optional feature macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them down.

module lsu_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [3:0]  mem_w_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // ---------------------------------------------------------------------------
  // Request decode (on the incoming request, used only when accepting in IDLE)
  // ---------------------------------------------------------------------------
  logic        req_legal;
  logic        req_reject;
  logic [31:0] req_eff_addr;

  always_comb begin
    if (req_we) begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      req_legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_misaligned;

  always_comb begin
    unique case (req_funct3[1:0])
      SZ_BYTE: req_misaligned = 1'b0;
      SZ_HALF: req_misaligned = req_addr[0];
      default: req_misaligned = |req_addr[1:0];
    endcase
  end

  assign req_reject   = !req_legal || req_misaligned;
  assign req_eff_addr = req_addr;
`else
  assign req_reject = !req_legal;

  // Misaligned halfword/word accesses are silently aligned down to their natural boundary.
  always_comb begin
    req_eff_addr = req_addr;
    unique case (req_funct3[1:0])
      SZ_BYTE: req_eff_addr = req_addr;
      SZ_HALF: req_eff_addr[0] = 1'b0;
      default: req_eff_addr[1:0] = 2'b00;
    endcase
  end
`endif

  // ---------------------------------------------------------------------------
  // Lane steering for the registered access
  // ---------------------------------------------------------------------------
  logic [1:0]  lane_off;
  logic [3:0]  lane_mask;
  logic [31:0] byte_mask;
  logic [31:0] store_data;
  logic [31:0] load_shifted;
  logic [31:0] load_data;

  assign lane_off = addr_q[1:0];

  always_comb begin
    unique case (funct3_q[1:0])
      SZ_BYTE: lane_mask = 4'b0001 << lane_off;
      SZ_HALF: lane_mask = 4'b0011 << {lane_off[1], 1'b0};
      default: lane_mask = 4'b1111;
    endcase
  end

  assign byte_mask  = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
  assign store_data = (wdata_q << {lane_off, 3'b000}) & byte_mask;

  // funct3[2] set means zero-extend (LBU/LHU).
  assign load_shifted = mem_dout >> {lane_off, 3'b000};

  always_comb begin
    unique case (funct3_q[1:0])
      SZ_BYTE: load_data = {{24{~funct3_q[2] & load_shifted[7]}}, load_shifted[7:0]};
      SZ_HALF: load_data = {{16{~funct3_q[2] & load_shifted[15]}}, load_shifted[15:0]};
      default: load_data = mem_dout;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    req_ready = 1'b0;
    mem_w_en  = 4'b0000;
    mem_addr  = 32'h0;
    mem_din   = 32'h0;
    rsp_valid = 1'b0;
    rsp_rdata = rdata_q;
    rsp_err   = err_q;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_eff_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          err_d    = req_reject;
          state_d  = req_reject ? RESP : ISSUE;
        end
      end

      ISSUE: begin
        mem_addr = {addr_q[31:2], 2'b00};
        if (we_q) begin
          mem_w_en = lane_mask;
          mem_din  = store_data;
          state_d  = RESP;
        end else begin
          state_d  = CAPTURE;
        end
      end

      CAPTURE: begin
        rdata_d = load_data;
        state_d = RESP;
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous and clears every field.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed vector table, reset-in-ISSUE sequence,
// and randomized accesses checked against a byte-level reference model.

module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  lsu_stage dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_w_en   (mem_w_en),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  // Synchronous-read data memory; the bench preloads words through its own write port.
  logic [31:0] dmem [0:255];
  logic        tb_wr_en;
  logic [7:0]  tb_wr_idx;
  logic [31:0] tb_wr_data;

  always @(posedge clk) begin
    mem_dout <= dmem[mem_addr[9:2]];
    if (tb_wr_en) dmem[tb_wr_idx] <= tb_wr_data;
    for (int i = 0; i < 4; i++) begin
      if (mem_w_en[i]) dmem[mem_addr[9:2]][8*i +: 8] <= mem_din[8*i +: 8];
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  wen;
    logic [31:0] din;
    logic [31:0] maddr;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre_en;
    logic [31:0] pre_word;
    int          hold;
    exp_t        e;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] word);
    tb_wr_en   = 1'b1;
    tb_wr_idx  = addr[9:2];
    tb_wr_data = word;
    @(posedge clk); #1;
    tb_wr_en   = 1'b0;
  endtask

  // Reference model: derives the access purely from size, offset and the extension rule.
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] word);
    exp_t        e;
    int          nbytes;
    int          off;
    logic        legal;
    logic [31:0] eff;
    logic [31:0] val;
    nbytes  = 1 << f3[1:0];
    legal   = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    e.err   = !legal;
    e.rdata = 32'h0;
    e.wen   = 4'h0;
    e.din   = 32'h0;
    e.maddr = 32'h0;
    e.lat   = 1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (legal && (addr % nbytes) != 0) e.err = 1'b1;
`endif
    if (!e.err) begin
      eff     = addr - (addr % nbytes);
      off     = int'(eff % 4);
      e.maddr = eff - off;
      if (we) begin
        e.lat = 2;
        for (int b = 0; b < nbytes; b++) begin
          e.wen[off + b]          = 1'b1;
          e.din[8*(off + b) +: 8] = wdata[8*b +: 8];
        end
      end else begin
        e.lat = 3;
        val   = 32'h0;
        for (int b = 0; b < nbytes; b++) val[8*b +: 8] = word[8*(off + b) +: 8];
        if (!f3[2] && nbytes < 4 && val[8*nbytes - 1]) begin
          for (int b = nbytes; b < 4; b++) val[8*b +: 8] = 8'hFF;
        end
        e.rdata = val;
      end
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic pre_en, input logic [31:0] pre_word,
                              input int hold, input logic err, input logic [31:0] rdata,
                              input logic [3:0] wen, input logic [31:0] din, input logic [31:0] maddr,
                              input int lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.pre_en = pre_en; v.pre_word = pre_word; v.hold = hold;
    v.e.err = err; v.e.rdata = rdata; v.e.wen = wen; v.e.din = din; v.e.maddr = maddr; v.e.lat = lat;
    return v;
  endfunction

  // One full transaction: accept, track latency and dmem activity, hold the response, handshake.
  task automatic run_txn(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input exp_t e, input int hold);
    logic [3:0]  wen_or;
    int          wen_cycles;
    logic [31:0] din_issue;
    logic [31:0] addr_issue;
    int          lat;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    lat        = 1;
    wen_or     = mem_w_en;
    wen_cycles = (mem_w_en != 4'h0) ? 1 : 0;
    din_issue  = mem_din;
    addr_issue = mem_addr;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      wen_or |= mem_w_en;
      if (mem_w_en != 4'h0) wen_cycles++;
    end
    check({tag, " latency"}, 32'(lat), 32'(e.lat));
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(e.err));
    check({tag, " rsp_rdata"}, rsp_rdata, e.rdata);
    if (!e.err) check({tag, " mem_addr"}, addr_issue, e.maddr);
    if (we && !e.err) check({tag, " mem_din"}, din_issue, e.din);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      wen_or |= mem_w_en;
      if (mem_w_en != 4'h0) wen_cycles++;
      check({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " hold rsp_rdata"}, rsp_rdata, e.rdata);
      check({tag, " hold rsp_err"}, 32'(rsp_err), 32'(e.err));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " mem_w_en"}, 32'(wen_or), 32'(e.wen));
    check({tag, " w_en cycles"}, 32'(wen_cycles), (e.wen != 4'h0) ? 32'd1 : 32'd0);
    check({tag, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  vec_t        tbl[$];
  logic [31:0] ref_mem [0:3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b0;
    tb_wr_en   = 1'b0;
    tb_wr_idx  = 8'h0;
    tb_wr_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset mem_w_en", 32'(mem_w_en), 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_din", mem_din, 32'h0);
    rst = 1'b0;

    //            we  f3      addr          wdata         pre   pre_word      hold err rdata         wen    din           maddr         lat
    tbl.push_back(mk(1, 3'b010, 32'h8000_0000, 32'h2022_1118, 0, 32'h0,         0, 0, 32'h0,         4'hF, 32'h2022_1118, 32'h8000_0000, 2));
    tbl.push_back(mk(1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 0, 32'h0,         0, 0, 32'h0,         4'h2, 32'h0000_AB00, 32'h8000_0000, 2));
    tbl.push_back(mk(1, 3'b001, 32'h8000_0002, 32'h0000_1234, 0, 32'h0,         0, 0, 32'h0,         4'hC, 32'h1234_0000, 32'h8000_0000, 2));
    tbl.push_back(mk(0, 3'b000, 32'h0010_0011, 32'h0,         1, 32'h80FF_1198, 0, 0, 32'h0000_0011, 4'h0, 32'h0,         32'h0010_0010, 3));
    tbl.push_back(mk(0, 3'b000, 32'h0010_0012, 32'h0,         1, 32'h80FF_1198, 0, 0, 32'hFFFF_FFFF, 4'h0, 32'h0,         32'h0010_0010, 3));
    tbl.push_back(mk(0, 3'b100, 32'h0010_0013, 32'h0,         1, 32'h80FF_1198, 0, 0, 32'h0000_0080, 4'h0, 32'h0,         32'h0010_0010, 3));
    tbl.push_back(mk(0, 3'b001, 32'h0010_0012, 32'h0,         1, 32'h80FF_1198, 1, 0, 32'hFFFF_80FF, 4'h0, 32'h0,         32'h0010_0010, 3));
    tbl.push_back(mk(0, 3'b101, 32'h0010_0012, 32'h0,         1, 32'h80FF_1198, 0, 0, 32'h0000_80FF, 4'h0, 32'h0,         32'h0010_0010, 3));
    tbl.push_back(mk(0, 3'b010, 32'h0010_0000, 32'h0,         1, 32'h1198_7251, 4, 0, 32'h1198_7251, 4'h0, 32'h0,         32'h0010_0000, 3));
    tbl.push_back(mk(0, 3'b011, 32'h0010_0000, 32'h0,         0, 32'h0,         2, 1, 32'h0,         4'h0, 32'h0,         32'h0,         1));
    tbl.push_back(mk(1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0,         0, 1, 32'h0,         4'h0, 32'h0,         32'h0,         1));
    tbl.push_back(mk(1, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0,         0, 1, 32'h0,         4'h0, 32'h0,         32'h0,         1));
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(0, 3'b010, 32'h0010_0002, 32'h0,         1, 32'h1198_7251, 1, 1, 32'h0,         4'h0, 32'h0,         32'h0,         1));
    tbl.push_back(mk(1, 3'b010, 32'h8000_0007, 32'hCAFE_F00D, 0, 32'h0,         0, 1, 32'h0,         4'h0, 32'h0,         32'h0,         1));
    tbl.push_back(mk(1, 3'b001, 32'h8000_0003, 32'hABCD_5678, 0, 32'h0,         0, 1, 32'h0,         4'h0, 32'h0,         32'h0,         1));
    tbl.push_back(mk(0, 3'b001, 32'h0010_0011, 32'h0,         1, 32'h80FF_1198, 0, 1, 32'h0,         4'h0, 32'h0,         32'h0,         1));
`else
    tbl.push_back(mk(0, 3'b010, 32'h0010_0002, 32'h0,         1, 32'h1198_7251, 1, 0, 32'h1198_7251, 4'h0, 32'h0,         32'h0010_0000, 3));
    tbl.push_back(mk(1, 3'b010, 32'h8000_0007, 32'hCAFE_F00D, 0, 32'h0,         0, 0, 32'h0,         4'hF, 32'hCAFE_F00D, 32'h8000_0004, 2));
    tbl.push_back(mk(1, 3'b001, 32'h8000_0003, 32'hABCD_5678, 0, 32'h0,         0, 0, 32'h0,         4'hC, 32'h5678_0000, 32'h8000_0000, 2));
    tbl.push_back(mk(0, 3'b001, 32'h0010_0011, 32'h0,         1, 32'h80FF_1198, 0, 0, 32'h0000_1198, 4'h0, 32'h0,         32'h0010_0010, 3));
`endif

    foreach (tbl[i]) begin
      if (tbl[i].pre_en) preload(tbl[i].addr, tbl[i].pre_word);
      run_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].e, tbl[i].hold);
    end

    // Reset during ISSUE of a word store: everything must be back to idle on the next cycle.
    check("rst-issue req_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0020_0000;
    req_wdata  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    check("rst-issue w_en in ISSUE", 32'(mem_w_en), 32'hF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst-issue req_ready", 32'(req_ready), 32'd1);
    check("rst-issue mem_w_en", 32'(mem_w_en), 32'h0);
    check("rst-issue rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst-issue rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    check("rst-issue stays idle", 32'(rsp_valid), 32'd0);
    check("rst-issue no late write", 32'(mem_w_en), 32'h0);

    // Randomized accesses over four words, checked against the reference model and memory image.
    for (int w = 0; w < 4; w++) begin
      ref_mem[w] = $urandom;
      preload(32'h0010_0000 + 32'(4 * w), ref_mem[w]);
    end
    for (int n = 0; n < 80; n++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_f3    = 3'($urandom_range(0, 7));
      r_addr  = 32'h0010_0000 | 32'($urandom_range(0, 15));
      r_wdata = $urandom;
      e = model(r_we, r_f3, r_addr, r_wdata, ref_mem[r_addr[3:2]]);
      run_txn($sformatf("rnd%0d", n), r_we, r_f3, r_addr, r_wdata, e, $urandom_range(0, 2));
      if (r_we && !e.err) begin
        for (int b = 0; b < 4; b++) begin
          if (e.wen[b]) ref_mem[e.maddr[3:2]][8*b +: 8] = e.din[8*b +: 8];
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
